fp_divide32_seq: RTL and testbench

//  Iterative IEEE-754 binary32 divider (o = a / b) with normalization and rounding.

---
 rtl/fp_divide32_seq_pkg.sv | 100 ++++++++++
 rtl/fp_div32_round.sv | 98 +++++++++
 rtl/fp_divide32_seq.sv | 276 +++++++++++++++++++++++++++
 tb/tb_fp_divide32_seq.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/fp_divide32_seq_pkg.sv
// ============================================================================
//  Module      : fp32Pkg (package)
//  Description : Shared FP32 types for the FPU datapath blocks: the binary32
//                field layout, rounding-mode encoding, special-value
//                constants, divider FSM states and an operand unpack helper.
//  Config      : FPDIV32_SUBNORM_EN - when defined, subnormal operands are
//                pre-normalized by unpack_op; otherwise they unpack as zero.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fp32Pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    // Encodings 5-7 are not listed; consumers treat them as RNE.
    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RUP = 3'd2,
        RM_RDN = 3'd3,
        RM_RMM = 3'd4
    } rm_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_UNPACK = 3'd1,
        S_DIV    = 3'd2,
        S_NORM   = 3'd3,
        S_ROUND  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [31:0] c_qnan    = 32'h7FC0_0000;
    localparam logic [30:0] c_inf_abs = 31'h7F80_0000;
    localparam logic [30:0] c_max_abs = 31'h7F7F_FFFF;
    localparam int          c_qbits   = 28;

    // Classified operand with hidden bit restored and an unbiased-offset
    // exponent wide enough for pre-normalized subnormals.
    typedef struct packed {
        logic              sign;
        logic              zero;
        logic              inf;
        logic              nan;
        logic              snan;
        logic [23:0]       mant;
        logic signed [9:0] exp;
    } op_t;

    // Leading-zero count of a 24-bit value (24 when the value is zero).
    function automatic logic [4:0] lzc24(input logic [23:0] v);
        logic [4:0] cnt;
        logic       found;
        cnt   = 5'd0;
        found = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      cnt   = cnt + 5'd1;
            end
        end
        return cnt;
    endfunction

    function automatic op_t unpack_op(input logic [31:0] f);
        fp32_t v;
        op_t   r;
`ifdef FPDIV32_SUBNORM_EN
        logic [4:0] lz;
`endif
        v      = f;
        r.sign = v.sign;
        r.inf  = (v.exp == 8'hFF) && (v.frac == 23'd0);
        r.nan  = (v.exp == 8'hFF) && (v.frac != 23'd0);
        r.snan = r.nan && !v.frac[22];
        r.mant = {1'b1, v.frac};
        r.exp  = $signed({2'b00, v.exp});
`ifdef FPDIV32_SUBNORM_EN
        r.zero = (v.exp == 8'h00) && (v.frac == 23'd0);
        if ((v.exp == 8'h00) && !r.zero) begin
            // Shift the fraction up to put a one in the hidden-bit position;
            // the effective exponent of a subnormal is 1 before the shift.
            lz     = lzc24({1'b0, v.frac});
            r.mant = {1'b0, v.frac} << lz;
            r.exp  = 10'sd1 - $signed({5'd0, lz});
        end
`else
        r.zero = (v.exp == 8'h00);
`endif
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fp_div32_round.sv
// ============================================================================
//  Module      : fp_div32_round
//  Description : Combinational rounder/packer for the FP32 divider. Takes a
//                normalized (or subnormal-aligned) 28-bit quotient plus
//                sticky, applies the rounding mode, detects overflow and
//                produces the packed result and exception flags.
//  Config      : FPDIV32_SUBNORM_EN - undefined: tiny results flush to signed
//                zero with underflow and inexact set.
//  Ports       : i_sign/i_exp/i_mant/i_sticky/i_tiny - quotient to round
//                i_rm                                - rounding mode
//                o_result                            - packed FP32 result
//                o_overflow/o_underflow/o_inexact    - exception flags
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_div32_round
    import fp32Pkg::*;
(
    input  logic              i_sign,
    input  logic signed [9:0] i_exp,
    input  logic [27:0]       i_mant,
    input  logic              i_sticky,
    input  logic              i_tiny,
    input  logic [2:0]        i_rm,
    output logic [31:0]       o_result,
    output logic              o_overflow,
    output logic              o_underflow,
    output logic              o_inexact
);

    logic        w_guard;
    logic        w_round;
    logic        w_stk;
    logic        w_lost;
    logic        w_inc;
    logic        w_to_max;
    logic        w_ovf;
    logic        w_flush;
    logic [7:0]  w_exp_field;
    logic [30:0] w_sum;

`ifdef FPDIV32_SUBNORM_EN
    assign w_flush = 1'b0;
`else
    assign w_flush = i_tiny;
`endif

    always_comb begin
        // Bit 3 is the half-ULP position below the 24-bit significand.
        w_guard = i_mant[3];
        w_round = i_mant[2];
        w_stk   = (|i_mant[1:0]) | i_sticky;
        w_lost  = w_guard | w_round | w_stk;

        case (i_rm)
            RM_RTZ:  w_inc = 1'b0;
            RM_RUP:  w_inc = ~i_sign & w_lost;
            RM_RDN:  w_inc = i_sign & w_lost;
            RM_RMM:  w_inc = w_guard;
            default: w_inc = w_guard & (w_round | w_stk | i_mant[4]);
        endcase

        // A subnormal-aligned quotient has no hidden bit and packs with a
        // zero exponent field; a rounding carry out of the fraction then
        // lands in the exponent field naturally.
        w_exp_field = i_mant[27] ? i_exp[7:0] : 8'd0;
        w_sum       = {w_exp_field, i_mant[26:4]} + {30'd0, w_inc};
        w_ovf       = (i_exp > 10'sd254) || (w_sum[30:23] == 8'hFF);

        // Overflow saturates to max finite when rounding toward zero or
        // when the directed mode points away from this sign's infinity.
        case (i_rm)
            RM_RTZ:  w_to_max = 1'b1;
            RM_RUP:  w_to_max = i_sign;
            RM_RDN:  w_to_max = ~i_sign;
            default: w_to_max = 1'b0;
        endcase

        o_result    = {i_sign, w_sum};
        o_overflow  = 1'b0;
        o_underflow = i_tiny & w_lost;
        o_inexact   = w_lost;
        if (w_flush) begin
            o_result    = {i_sign, 31'd0};
            o_underflow = 1'b1;
            o_inexact   = 1'b1;
        end else if (w_ovf) begin
            o_result    = {i_sign, (w_to_max ? c_max_abs : c_inf_abs)};
            o_overflow  = 1'b1;
            o_underflow = 1'b0;
            o_inexact   = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fp_divide32_seq.sv
// ============================================================================
//  Module      : fp_divide32_seq
//  Description : Iterative IEEE-754 binary32 divider (o = a / b). One divide
//                in flight; ld/done handshake. Restoring radix-2 mantissa
//                division retiring ITER_PER_CLK quotient bits per clock.
//  Config      : FPDIV32_SUBNORM_EN - subnormal inputs/outputs supported when
//                defined; flush-to-zero behaviour otherwise.
//  Ports       : clk, rst_n (async, active-low), ce (clock enable)
//                ld, a, b, rm      - start request and operands
//                o, done, busy     - result, one-cycle done pulse, busy
//                divzero, invalid, overflow, underflow, inexact - flags
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_divide32_seq
    import fp32Pkg::*;
#(
    parameter int ITER_PER_CLK = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce,
    input  logic        ld,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  rm,
    output logic [31:0] o,
    output logic        done,
    output logic        busy,
    output logic        divzero,
    output logic        invalid,
    output logic        overflow,
    output logic        underflow,
    output logic        inexact
);

    localparam int         c_div_cyc  = c_qbits / ITER_PER_CLK;
    localparam logic [4:0] c_cnt_init = 5'(c_div_cyc - 1);

    state_t            r_state;
    logic [31:0]       r_a;
    logic [31:0]       r_b;
    logic [2:0]        r_rm;
    logic              r_sign;
    logic signed [9:0] r_exp;
    logic [24:0]       r_rem;
    logic [23:0]       r_div;
    logic [27:0]       r_q;
    logic [4:0]        r_cnt;
    logic              r_sticky;
    logic              r_tiny;
    logic [31:0]       r_o;
    logic              r_done;
    logic              r_busy;
    logic              r_divzero;
    logic              r_invalid;
    logic              r_overflow;
    logic              r_underflow;
    logic              r_inexact;

    // ---------------- unpack / special-case detection ----------------
    op_t               w_ua;
    op_t               w_ub;
    logic              w_sign;
    logic signed [9:0] w_exp;
    logic              w_spec;
    logic [31:0]       w_spec_o;
    logic              w_spec_dz;
    logic              w_spec_inv;

    always_comb begin
        w_ua       = unpack_op(r_a);
        w_ub       = unpack_op(r_b);
        w_sign     = w_ua.sign ^ w_ub.sign;
        w_exp      = w_ua.exp - w_ub.exp + 10'sd127;
        w_spec     = 1'b1;
        w_spec_o   = {w_sign, 31'd0};
        w_spec_dz  = 1'b0;
        w_spec_inv = 1'b0;
        if (w_ua.nan || w_ub.nan) begin
            w_spec_o   = c_qnan;
            w_spec_inv = w_ua.snan | w_ub.snan;
        end else if ((w_ua.zero && w_ub.zero) || (w_ua.inf && w_ub.inf)) begin
            w_spec_o   = c_qnan;
            w_spec_inv = 1'b1;
        end else if (w_ub.zero) begin
            w_spec_o  = {w_sign, c_inf_abs};
            w_spec_dz = ~w_ua.inf;
        end else if (w_ua.inf) begin
            w_spec_o = {w_sign, c_inf_abs};
        end else if (w_ua.zero || w_ub.inf) begin
            w_spec_o = {w_sign, 31'd0};
        end else begin
            w_spec = 1'b0;
        end
    end

    // ---------------- restoring division step(s) ----------------
    // The partial remainder stays below twice the divisor, so 25 bits hold
    // it across the shift without loss.
    logic [24:0] w_rem_nx;
    logic [27:0] w_q_nx;

    always_comb begin
        w_rem_nx = r_rem;
        w_q_nx   = r_q;
        for (int i = 0; i < ITER_PER_CLK; i++) begin
            if (w_rem_nx >= {1'b0, r_div}) begin
                w_rem_nx = w_rem_nx - {1'b0, r_div};
                w_q_nx   = {w_q_nx[26:0], 1'b1};
            end else begin
                w_q_nx   = {w_q_nx[26:0], 1'b0};
            end
            w_rem_nx = w_rem_nx << 1;
        end
    end

    // ---------------- normalization ----------------
    logic [27:0]       w_nq;
    logic signed [9:0] w_nexp;
    logic              w_nsticky;
    logic              w_ntiny;
`ifdef FPDIV32_SUBNORM_EN
    logic signed [9:0] w_sh;
    logic [27:0]       w_shout;
`endif

    always_comb begin
        w_nq      = r_q;
        w_nexp    = r_exp;
        w_nsticky = |r_rem;
        // Quotient of two [1,2) significands lies in (0.5,2): at most one
        // left shift puts the leading one in bit 27.
        if (!r_q[27]) begin
            w_nq   = {r_q[26:0], 1'b0};
            w_nexp = r_exp - 10'sd1;
        end
        w_ntiny = (w_nexp < 10'sd1);
`ifdef FPDIV32_SUBNORM_EN
        w_sh    = 10'sd1 - w_nexp;
        w_shout = 28'd0;
        if (w_ntiny) begin
            if (w_sh > 10'sd27) begin
                w_nsticky = w_nsticky | (|w_nq);
                w_nq      = 28'd0;
            end else begin
                {w_nq, w_shout} = {w_nq, 28'd0} >> w_sh;
                w_nsticky       = w_nsticky | (|w_shout);
            end
        end
`endif
    end

    // ---------------- rounding ----------------
    logic [31:0] w_rnd_o;
    logic        w_rnd_ovf;
    logic        w_rnd_unf;
    logic        w_rnd_inx;

    fp_div32_round u_round (
        .i_sign      (r_sign),
        .i_exp       (r_exp),
        .i_mant      (r_q),
        .i_sticky    (r_sticky),
        .i_tiny      (r_tiny),
        .i_rm        (r_rm),
        .o_result    (w_rnd_o),
        .o_overflow  (w_rnd_ovf),
        .o_underflow (w_rnd_unf),
        .o_inexact   (w_rnd_inx)
    );

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_a         <= 32'd0;
            r_b         <= 32'd0;
            r_rm        <= 3'd0;
            r_sign      <= 1'b0;
            r_exp       <= 10'sd0;
            r_rem       <= 25'd0;
            r_div       <= 24'd0;
            r_q         <= 28'd0;
            r_cnt       <= 5'd0;
            r_sticky    <= 1'b0;
            r_tiny      <= 1'b0;
            r_o         <= 32'd0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
            r_divzero   <= 1'b0;
            r_invalid   <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_inexact   <= 1'b0;
        end else if (ce) begin
            case (r_state)
                S_IDLE: begin
                    if (ld) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_rm    <= rm;
                        r_busy  <= 1'b1;
                        r_state <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    if (w_spec) begin
                        r_o         <= w_spec_o;
                        r_divzero   <= w_spec_dz;
                        r_invalid   <= w_spec_inv;
                        r_overflow  <= 1'b0;
                        r_underflow <= 1'b0;
                        r_inexact   <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_sign  <= w_sign;
                        r_exp   <= w_exp;
                        r_rem   <= {1'b0, w_ua.mant};
                        r_div   <= w_ub.mant;
                        r_q     <= 28'd0;
                        r_cnt   <= c_cnt_init;
                        r_state <= S_DIV;
                    end
                end
                S_DIV: begin
                    r_rem <= w_rem_nx;
                    r_q   <= w_q_nx;
                    if (r_cnt == 5'd0) r_state <= S_NORM;
                    else               r_cnt   <= r_cnt - 5'd1;
                end
                S_NORM: begin
                    r_q      <= w_nq;
                    r_exp    <= w_nexp;
                    r_sticky <= w_nsticky;
                    r_tiny   <= w_ntiny;
                    r_state  <= S_ROUND;
                end
                S_ROUND: begin
                    r_o         <= w_rnd_o;
                    r_divzero   <= 1'b0;
                    r_invalid   <= 1'b0;
                    r_overflow  <= w_rnd_ovf;
                    r_underflow <= w_rnd_unf;
                    r_inexact   <= w_rnd_inx;
                    r_done      <= 1'b1;
                    r_state     <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o         = r_o;
    assign done      = r_done;
    assign busy      = r_busy;
    assign divzero   = r_divzero;
    assign invalid   = r_invalid;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;
    assign inexact   = r_inexact;

endmodule

`default_nettype wire

// File: tb/tb_fp_divide32_seq.sv
// ============================================================================
//  Module      : tb_fp_divide32_seq
//  Description : Directed self-checking bench for fp_divide32_seq: hand-
//                computed quotients, flags and done latency, plus handshake
//                behaviour (ignored ld, clock-enable stall, async abort).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_divide32_seq;

    localparam int ITER = 1;
    localparam int LAT_N = 3 + 28 / ITER;
    localparam int LAT_S = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce;
    logic        ld;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  rm;
    logic [31:0] o;
    logic        done;
    logic        busy;
    logic        divzero;
    logic        invalid;
    logic        overflow;
    logic        underflow;
    logic        inexact;

    int n_total = 0;
    int n_bad   = 0;

    fp_divide32_seq #(.ITER_PER_CLK(ITER)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ce        (ce),
        .ld        (ld),
        .a         (a),
        .b         (b),
        .rm        (rm),
        .o         (o),
        .done      (done),
        .busy      (busy),
        .divzero   (divzero),
        .invalid   (invalid),
        .overflow  (overflow),
        .underflow (underflow),
        .inexact   (inexact)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] flags();
        return {27'd0, divzero, invalid, overflow, underflow, inexact};
    endfunction

    // Start one divide and count edges after the ld edge until done (-1 on timeout).
    task automatic do_div(input logic [31:0] ta, input logic [31:0] tb, input logic [2:0] trm,
                          output int lat);
        @(posedge clk);
        @(negedge clk);
        a = ta; b = tb; rm = trm; ld = 1'b1;
        @(posedge clk); #1;
        ld = 1'b0; a = 32'hDEAD_BEEF; b = 32'h0; rm = 3'd1;
        lat = 0;
        while (!done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!done) lat = -1;
    endtask

    // Flags expected as {divzero, invalid, overflow, underflow, inexact}.
    task automatic run_vec(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                           input logic [2:0] trm, input logic [31:0] eo, input logic [4:0] efl,
                           input int elat);
        int lat;
        do_div(ta, tb, trm, lat);
        check_eq({tag, ".o"}, o, eo);
        check_eq({tag, ".flags"}, flags(), {27'd0, efl});
        check_eq({tag, ".lat"}, 32'(lat), 32'(elat));
    endtask

    // 6.0/2.0 with per-edge control of ld, ce and rst_n (edge numbers, -1 = unused).
    task automatic ctl_run(input int ld_e1, input int ld_e2, input int rst_e,
                           input int ce_e, input int ce_len,
                           output int lat, output logic busy_mid);
        @(posedge clk);
        @(negedge clk);
        a = 32'h40C0_0000; b = 32'h4000_0000; rm = 3'd0; ld = 1'b1;
        @(posedge clk); #1;
        ld = 1'b0;
        lat = -1;
        busy_mid = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            ld    = (k == ld_e1) || (k == ld_e2);
            ce    = !(k >= ce_e && k < ce_e + ce_len);
            rst_n = (k != rst_e);
            if (ld) begin
                a = 32'h3F80_0000; b = 32'h0;
            end
            @(posedge clk); #1;
            if (k == 3) busy_mid = busy;
            if (done) begin
                lat = k;
                break;
            end
        end
        ld = 1'b0; ce = 1'b1; rst_n = 1'b1;
    endtask

    initial begin
        int   lat;
        logic bm;
        rst_n = 1'b0; ce = 1'b1; ld = 1'b0; a = 32'h0; b = 32'h0; rm = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst.o", o, 32'h0);
        check_eq("rst.done", {31'd0, done}, 32'd0);
        check_eq("rst.busy", {31'd0, busy}, 32'd0);
        check_eq("rst.flags", flags(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_vec("6div2",     32'h40C0_0000, 32'h4000_0000, 3'd0, 32'h4040_0000, 5'b00000, LAT_N);
        run_vec("1div3.rne", 32'h3F80_0000, 32'h4040_0000, 3'd0, 32'h3EAA_AAAB, 5'b00001, LAT_N);
        run_vec("1div3.rtz", 32'h3F80_0000, 32'h4040_0000, 3'd1, 32'h3EAA_AAAA, 5'b00001, LAT_N);
        run_vec("1div3.rup", 32'h3F80_0000, 32'h4040_0000, 3'd2, 32'h3EAA_AAAB, 5'b00001, LAT_N);
        run_vec("1div3.rdn", 32'h3F80_0000, 32'h4040_0000, 3'd3, 32'h3EAA_AAAA, 5'b00001, LAT_N);
        run_vec("1div3.rmm", 32'h3F80_0000, 32'h4040_0000, 3'd4, 32'h3EAA_AAAB, 5'b00001, LAT_N);
        run_vec("1div3.rm6", 32'h3F80_0000, 32'h4040_0000, 3'd6, 32'h3EAA_AAAB, 5'b00001, LAT_N);
        run_vec("1div1p5",   32'h3F80_0000, 32'h3FC0_0000, 3'd0, 32'h3F2A_AAAB, 5'b00001, LAT_N);
        run_vec("neg6div2",  32'hC0C0_0000, 32'h4000_0000, 3'd0, 32'hC040_0000, 5'b00000, LAT_N);
        run_vec("1div0",     32'h3F80_0000, 32'h0000_0000, 3'd0, 32'h7F80_0000, 5'b10000, LAT_S);
        run_vec("0div0",     32'h0000_0000, 32'h0000_0000, 3'd0, 32'h7FC0_0000, 5'b01000, LAT_S);
        run_vec("infdivinf", 32'h7F80_0000, 32'hFF80_0000, 3'd0, 32'h7FC0_0000, 5'b01000, LAT_S);
        run_vec("snan",      32'h7F80_0001, 32'h3F80_0000, 3'd0, 32'h7FC0_0000, 5'b01000, LAT_S);
        run_vec("qnandiv0",  32'h7FC0_0000, 32'h0000_0000, 3'd0, 32'h7FC0_0000, 5'b00000, LAT_S);
        run_vec("2divinf",   32'h4000_0000, 32'h7F80_0000, 3'd0, 32'h0000_0000, 5'b00000, LAT_S);
        run_vec("ovf.rne",   32'h7F7F_FFFF, 32'h3E80_0000, 3'd0, 32'h7F80_0000, 5'b00101, LAT_N);
        run_vec("ovf.rtz",   32'h7F7F_FFFF, 32'h3E80_0000, 3'd1, 32'h7F7F_FFFF, 5'b00101, LAT_N);
        run_vec("novf.rup",  32'hFF7F_FFFF, 32'h3E80_0000, 3'd2, 32'hFF7F_FFFF, 5'b00101, LAT_N);
        run_vec("novf.rdn",  32'hFF7F_FFFF, 32'h3E80_0000, 3'd3, 32'hFF80_0000, 5'b00101, LAT_N);
`ifdef FPDIV32_SUBNORM_EN
        run_vec("tiny",      32'h0080_0000, 32'h4000_0000, 3'd0, 32'h0040_0000, 5'b00000, LAT_N);
        run_vec("subin",     32'h0040_0000, 32'h3F00_0000, 3'd0, 32'h0080_0000, 5'b00000, LAT_N);
`else
        run_vec("tiny",      32'h0080_0000, 32'h4000_0000, 3'd0, 32'h0000_0000, 5'b00011, LAT_N);
        run_vec("subin",     32'h0040_0000, 32'h3F00_0000, 3'd0, 32'h0000_0000, 5'b00000, LAT_S);
`endif

        // ld pulses mid-divide must not disturb the running operation.
        ctl_run(5, 20, -1, -1, 0, lat, bm);
        check_eq("ldbusy.lat", 32'(lat), 32'(LAT_N));
        check_eq("ldbusy.o", o, 32'h4040_0000);
        check_eq("ldbusy.busy", {31'd0, bm}, 32'd1);

        // Three frozen cycles delay done by three.
        ctl_run(-1, -1, -1, 5, 3, lat, bm);
        check_eq("ce.lat", 32'(lat), 32'(LAT_N + 3));
        check_eq("ce.o", o, 32'h4040_0000);

        // Reset mid-divide aborts without done and clears the result.
        ctl_run(-1, -1, 10, -1, 0, lat, bm);
        check_eq("abort.lat", 32'(lat), 32'hFFFF_FFFF);
        check_eq("abort.busy", {31'd0, busy}, 32'd0);
        check_eq("abort.o", o, 32'h0);

        // Divider still usable after the abort.
        run_vec("post", 32'h40C0_0000, 32'h4000_0000, 3'd0, 32'h4040_0000, 5'b00000, LAT_N);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
